// File: rtl/dm_arbiter.sv
// dm_arbiter: two-port arbiter in front of a single-ported data memory.
// Each access takes three cycles: IDLE (grant), ACCESS (memory cycle) and RESP (ack pulse).
// Optional macro DM_ARBITER_ROUND_ROBIN_EN: simultaneous requests alternate between ports.
// Without it, port 0 always wins a tie.
module dm_arbiter #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p0_req,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    input  logic [3:0]    p0_byteen,
    output logic          p0_ack,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    input  logic [3:0]    p1_byteen,
    output logic          p1_ack,
    output logic [DW-1:0] p1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [3:0]    mem_byteen,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam int unsigned BE_W = 4;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    logic [1:0]      state_q,      state_d;
    logic            grant_q,      grant_d;
    logic            p0_ack_q,     p0_ack_d;
    logic            p1_ack_q,     p1_ack_d;
    logic [DW-1:0]   p0_rdata_q,   p0_rdata_d;
    logic [DW-1:0]   p1_rdata_q,   p1_rdata_d;
    logic [AW-1:0]   mem_addr_q,   mem_addr_d;
    logic [DW-1:0]   mem_wdata_q,  mem_wdata_d;
    logic [BE_W-1:0] mem_byteen_q, mem_byteen_d;
    logic            busy_q,       busy_d;
    logic            win_c;
`ifdef DM_ARBITER_ROUND_ROBIN_EN
    logic            last_q,       last_d;
`endif

    // Winner selection for the IDLE grant (1 = port 1)
    always_comb begin
        win_c = 1'b0;
`ifdef DM_ARBITER_ROUND_ROBIN_EN
        win_c = p1_req & (~p0_req | ~last_q);
`else
        win_c = p1_req & ~p0_req;
`endif
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        p0_ack_d     = 1'b0;
        p1_ack_d     = 1'b0;
        p0_rdata_d   = p0_rdata_q;
        p1_rdata_d   = p1_rdata_q;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        mem_byteen_d = '0;
        busy_d       = 1'b0;
`ifdef DM_ARBITER_ROUND_ROBIN_EN
        last_d       = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (p0_req || p1_req) begin
                    // Latch the winner's request straight into the memory-port registers
                    grant_d = win_c;
                    if (win_c) begin
                        mem_addr_d   = p1_addr & ~AW'(3);
                        mem_wdata_d  = p1_wdata;
                        mem_byteen_d = p1_byteen;
                    end else begin
                        mem_addr_d   = p0_addr & ~AW'(3);
                        mem_wdata_d  = p0_wdata;
                        mem_byteen_d = p0_byteen;
                    end
`ifdef DM_ARBITER_ROUND_ROBIN_EN
                    last_d  = win_c;
`endif
                    busy_d  = 1'b1;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                // Capture the pre-write word on the same edge the memory commits any write
                if (grant_q) begin
                    p1_rdata_d = mem_rdata;
                    p1_ack_d   = 1'b1;
                end else begin
                    p0_rdata_d = mem_rdata;
                    p0_ack_d   = 1'b1;
                end
                busy_d  = 1'b1;
                state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            p0_ack_q     <= 1'b0;
            p1_ack_q     <= 1'b0;
            p0_rdata_q   <= '0;
            p1_rdata_q   <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_byteen_q <= '0;
            busy_q       <= 1'b0;
`ifdef DM_ARBITER_ROUND_ROBIN_EN
            last_q       <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            p0_ack_q     <= p0_ack_d;
            p1_ack_q     <= p1_ack_d;
            p0_rdata_q   <= p0_rdata_d;
            p1_rdata_q   <= p1_rdata_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_byteen_q <= mem_byteen_d;
            busy_q       <= busy_d;
`ifdef DM_ARBITER_ROUND_ROBIN_EN
            last_q       <= last_d;
`endif
        end
    end

    assign p0_ack     = p0_ack_q;
    assign p1_ack     = p1_ack_q;
    assign p0_rdata   = p0_rdata_q;
    assign p1_rdata   = p1_rdata_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = busy_q;
    // Reset gates the write strobe so an aborted ACCESS never commits on the reset edge
    assign mem_byteen = reset ? mem_byteen_q : 4'b0000;

endmodule
